// File: rtl/array_swap_seq.sv
// array_swap_seq: multi-cycle sequencer that swaps two equal-length word
// arrays held in a single-port, word-addressed store.
//
// One command (base A, base B, length) is accepted at a time from IDLE.
// CHECK validates the command without touching the store. Each word then
// takes four store cycles: read A, read B, write A, write B. DONE pulses
// done, with err qualifying a rejected command.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE, so cmd_valid
// while busy is neither accepted nor queued. The requester keeps cmd_valid
// and the fields stable until it sees cmd_ready.
//
// Store timing: mem_rdata is valid exactly one cycle after a read strobe.
//
// Optional build macro ARRAY_SWAP_PERF_EN adds two performance counters:
// perf_cycles (busy cycles since reset, saturating) and perf_words
// (completed word swaps).
//
// dbg_state exposes the FSM state encoding for debug and checkers.

module array_swap_seq #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 8,
    parameter int MEM_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr_a,
    input  logic [ADDR_W-1:0] cmd_addr_b,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
`ifdef ARRAY_SWAP_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_words
`endif
);

    // Range checks are done one bit wider than the operands so that
    // base + length never wraps.
    localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
    localparam logic [SUM_W-1:0] MEM_LIMIT = SUM_W'(MEM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_RD_A  = 3'd2,
        S_RD_B  = 3'd3,
        S_WR_A  = 3'd4,
        S_WR_B  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   a_q, a_d;
    logic [ADDR_W-1:0]   b_q, b_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   tmp_a_q, tmp_a_d;
    // tmp_b holds the B word seen during WR_A; kept for debug visibility only.
    logic [DATA_W-1:0]   tmp_b_q, tmp_b_d;
    logic                err_q, err_d;

    // Extended operands for the CHECK-state range and overlap tests.
    logic [SUM_W-1:0]    a_ext, b_ext, len_ext, a_end, b_end;
    logic [ADDR_W-1:0]   addr_a_idx, addr_b_idx;
    logic                last_word;
    state_t              chk_next;
    logic                chk_err;

    assign a_ext      = SUM_W'(a_q);
    assign b_ext      = SUM_W'(b_q);
    assign len_ext    = SUM_W'(len_q);
    assign a_end      = a_ext + len_ext;
    assign b_end      = b_ext + len_ext;
    assign addr_a_idx = a_q + ADDR_W'(idx_q);
    assign addr_b_idx = b_q + ADDR_W'(idx_q);
    assign last_word  = (idx_q == (len_q - LEN_W'(1)));
    assign dbg_state  = state_q;

    // CHECK decision: trivial commands finish cleanly, bad ranges are rejected.
    always_comb begin
        chk_next = S_RD_A;
        chk_err  = 1'b0;
        if (len_q == '0) begin
            chk_next = S_DONE;
        end else if (a_q == b_q) begin
            chk_next = S_DONE;
        end else if ((a_end > MEM_LIMIT) || (b_end > MEM_LIMIT)) begin
            chk_next = S_DONE;
            chk_err  = 1'b1;
        end else if ((a_ext < b_end) && (b_ext < a_end)) begin
            chk_next = S_DONE;
            chk_err  = 1'b1;
        end
    end

    // Next-state, datapath updates and store/handshake outputs.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        len_d     = len_q;
        idx_d     = idx_q;
        tmp_a_d   = tmp_a_q;
        tmp_b_d   = tmp_b_q;
        err_d     = err_q;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    a_d     = cmd_addr_a;
                    b_d     = cmd_addr_b;
                    len_d   = cmd_len;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                err_d   = chk_err;
                state_d = chk_next;
            end
            S_RD_A: begin
                mem_en   = 1'b1;
                mem_addr = addr_a_idx;
                state_d  = S_RD_B;
            end
            S_RD_B: begin
                // mem_rdata now carries the A word read in RD_A.
                mem_en   = 1'b1;
                mem_addr = addr_b_idx;
                tmp_a_d  = mem_rdata;
                state_d  = S_WR_A;
            end
            S_WR_A: begin
                // mem_rdata now carries the B word; write it straight to A.
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_a_idx;
                mem_wdata = mem_rdata;
                tmp_b_d   = mem_rdata;
                state_d   = S_WR_B;
            end
            S_WR_B: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_b_idx;
                mem_wdata = tmp_a_q;
                if (last_word) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + LEN_W'(1);
                    state_d = S_RD_A;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // While reset is held the outputs show their idle values, so an
        // in-flight write is dropped rather than landing in the store.
        if (rst) begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            done      = 1'b0;
            err       = 1'b0;
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            tmp_a_q <= '0;
            tmp_b_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            tmp_a_q <= tmp_a_d;
            tmp_b_q <= tmp_b_d;
            err_q   <= err_d;
        end
    end

`ifdef ARRAY_SWAP_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_words_q, perf_words_d;

    // Busy-cycle counter saturates; word counter steps once per WR_B.
    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_words_d  = perf_words_q;
        if ((state_q != S_IDLE) && (perf_cycles_q != 32'hFFFF_FFFF)) begin
            perf_cycles_d = perf_cycles_q + 32'd1;
        end
        if (state_q == S_WR_B) begin
            perf_words_d = perf_words_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles_q <= '0;
            perf_words_q  <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_words_q  <= perf_words_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_words  = perf_words_q;
`endif

endmodule

// File: doc/array_swap_seq.md
Name: array_swap_seq

Overview:
- Multi-cycle sequencer that performs the array-swap operation word by word against a single-port, word-addressed u32 store.
- The store is a unified address space holding the data, shared and thread regions.
- Replaces the single-cycle combinational swap wherever the regions live in RAM instead of flops.
- Accepts one command at a time: address A, address B, length. Swaps mem[A+i] with mem[B+i] for i = 0..len-1, then pulses done.

Parameters:
- ADDR_W, 8, word-address width of the store
- DATA_W, 32, word width (u32 lanes)
- LEN_W, 8, width of the length field
- MEM_WORDS, 256, number of valid words; any access at or above this index is out of range

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
- cmd_addr_a  in  ADDR_W  first array base
- cmd_addr_b  in  ADDR_W  second array base
- cmd_len  in  LEN_W  number of words to swap
- mem_en  out  1  store access strobe
- mem_we  out  1  write when 1, read when 0 (qualified by mem_en)
- mem_addr  out  ADDR_W  store word address
- mem_wdata  out  DATA_W  store write data
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after a read strobe
- busy  out  1  command in progress (high in every state except IDLE)
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done: command rejected, no writes performed

Behaviour:
- Reset values: cmd_ready=1, busy=0, done=0, err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0; FSM enters IDLE, index cleared.
- Accept: a command is taken on a cycle with cmd_valid && cmd_ready. Fields are latched into a_reg, b_reg, len_reg; idx is set to 0.
- States: IDLE, CHECK, RD_A, RD_B, WR_A, WR_B, DONE.
- IDLE -> CHECK on accept.
- CHECK takes one cycle with no store access. Exit conditions:
  - len_reg==0 -> DONE, err=0.
  - a_reg==b_reg -> DONE, err=0 (no-op).
  - a_reg+len_reg > MEM_WORDS or b_reg+len_reg > MEM_WORDS -> DONE, err=1. Compute at ADDR_W+1 bits; no wrap.
  - [a,a+len) and [b,b+len) intersect -> DONE, err=1.
  - Otherwise -> RD_A.
- RD_A: read strobe at a_reg+idx.
- RD_B: read strobe at b_reg+idx; capture mem_rdata into tmp_a at the clock edge.
- WR_A: write strobe at a_reg+idx with wdata=mem_rdata (the B word, driven combinationally); capture mem_rdata into tmp_b.
- WR_B: write strobe at b_reg+idx with wdata=tmp_a.
- WR_B exit: if idx==len_reg-1 -> DONE, else idx++ -> RD_A.
- DONE: done=1 and err as decided, for one cycle; then -> IDLE with cmd_ready=1 on the following cycle.
- mem_en=0 in IDLE, CHECK and DONE. Exactly 4 store accesses per word, in order A-read, B-read, A-write, B-write.
- Latency from accept to done for a valid swap: 1 (CHECK) + 4*len + 1 cycles. A rejected or no-op command gives done 2 cycles after accept.
- cmd_valid while busy is ignored (not queued); the requester holds it until cmd_ready.
- done and cmd_ready are never high in the same cycle.
- Reset mid-operation returns to IDLE in the next cycle. Words already written stay swapped and there is no rollback. No done is issued for the aborted command.
- tmp_b is retained for debug only; the swap does not depend on it.

Optional Feature:
- Macro ARRAY_SWAP_PERF_EN.
- When defined, adds output perf_cycles [31:0]: count of cycles with busy=1 since reset. Cleared by rst, saturates at 0xFFFFFFFF, also incremented on the DONE cycle.
- Adds output perf_words [31:0]: count of completed word swaps, incremented on each WR_B cycle.
- Without the macro neither port nor its counters exist, and all other behaviour is identical.

Test Plan:
- mem[0..3]=10,11,12,13 and mem[64..65]=0; cmd a=0,b=64,len=2 -> done at cycle 10 after accept, err=0; mem[0..1]=0,0, mem[64..65]=10,11, mem[2..3] unchanged.
- a=2,b=133,len=3 with mem[2..4]=-24,47,26 and mem[133..135]=57,-375,357 -> swapped values; mem[1], mem[5], mem[132], mem[136] unchanged; access trace is exactly 12 strobes in R,R,W,W order.
- len=0 and a=b=7,len=4 -> done 2 cycles after accept, err=0, mem_en never asserted.
- a=10,b=12,len=4 (overlap) and a=250,b=0,len=8 (out of range, MEM_WORDS=256) -> done with err=1, zero writes.
- rst asserted during WR_A of word 2 of a len=5 swap -> IDLE next cycle, words 0..1 swapped, word 2 onward untouched, no done; a new command is accepted afterwards.
- cmd_valid held high across a busy period with a second command -> second command accepted only on the first cycle cmd_ready=1 after done; with ARRAY_SWAP_PERF_EN defined, perf_words=len1+len2.
